ball_collision_responder: RTL and testbench

//  Consumer end of the per-frame collision pulses from the collision detector. Per frame: latches

---
 rtl/ball_collision_responder.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ball_collision_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_collision_responder.sv
// Collects one frame's collision pulses, resolves them by priority and updates ball speed/score/life.
// Latency: results and speedValid appear on the 2nd clk after the startOfFrame that closes the frame.
// No backpressure: a startOfFrame that arrives while busy is held pending, so no frame is lost.
module ball_collision_responder #(
  parameter int SPEED_W       = 11,
  parameter int MAX_SPEED     = 240,
  parameter int GRAVITY       = 8,
  parameter int SPRING_SPEED  = 200,
  parameter int FLIPPER_BOOST = 40,
  parameter int BUMPER_BOOST  = 24,
  parameter int GOOD_POINTS   = 10,
  parameter int BAD_POINTS    = 5,
  parameter int TRAP_FRAMES   = 60,
  parameter int BALL_SIZE     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               collisionBallFrame,
  input  logic               collisionBallFlipper,
  input  logic               collisionBallObstacleGood,
  input  logic               collisionBallObstacleBad,
  input  logic               collisionBallSpring,
  input  logic               collisionBallBumper,
  input  logic               collisionBallTrap,
  input  logic               collisionBallBottom,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  input  logic [10:0]        ballX,
  input  logic [10:0]        ballY,
  output logic [SPEED_W-1:0] speedX,
  output logic [SPEED_W-1:0] speedY,
  output logic               speedValid,
  output logic [7:0]         scoreDelta,
  output logic               scoreValid,
  output logic               lifeLost,
  output logic               trapped
);

  // Arithmetic is done one bit wider than the speed so sums cannot wrap before clamping.
  localparam int W  = SPEED_W + 1;
  localparam int TW = $clog2(TRAP_FRAMES + 1);

  localparam logic signed [W-1:0] MAX_W  = W'(MAX_SPEED);
  localparam logic signed [W-1:0] NMAX_W = -MAX_W;
  localparam logic signed [W-1:0] GRAV_W = W'(GRAVITY);
  localparam logic signed [W-1:0] SPR_W  = W'(SPRING_SPEED);
  localparam logic signed [W-1:0] FB_W   = W'(FLIPPER_BOOST);
  localparam logic signed [W-1:0] BB_W   = W'(BUMPER_BOOST);
  localparam logic [7:0]          GOOD_D = 8'(GOOD_POINTS);
  localparam logic [7:0]          BAD_D  = 8'(-BAD_POINTS);
  localparam logic [TW-1:0]       TRAP_LOAD = TW'(TRAP_FRAMES);
  localparam logic [TW-1:0]       T_ONE  = TW'(1);
  localparam logic signed [12:0]  HALF   = 13'(BALL_SIZE / 2);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_RESOLVE = 2'd1;
  localparam logic [1:0] S_APPLY   = 2'd2;

  // Resolved collision class, carried from RESOLVE into APPLY.
  localparam logic [3:0] C_NONE    = 4'd0;
  localparam logic [3:0] C_FRAME   = 4'd1;
  localparam logic [3:0] C_BAD     = 4'd2;
  localparam logic [3:0] C_GOOD    = 4'd3;
  localparam logic [3:0] C_BUMPER  = 4'd4;
  localparam logic [3:0] C_FLIPPER = 4'd5;
  localparam logic [3:0] C_SPRING  = 4'd6;
  localparam logic [3:0] C_BOTTOM  = 4'd7;
  localparam logic [3:0] C_TRAP    = 4'd8;
  localparam logic [3:0] C_HOLD    = 4'd9;

  // Bit positions inside the flag vectors.
  localparam int F_FRAME  = 0;
  localparam int F_FLIP   = 1;
  localparam int F_GOOD   = 2;
  localparam int F_BAD    = 3;
  localparam int F_SPRING = 4;
  localparam int F_BUMPER = 5;
  localparam int F_TRAP   = 6;
  localparam int F_BOTTOM = 7;

  logic [1:0]  state;
  logic        pending;
  logic [7:0]  pulses, live, snap;
  logic        live_h, live_neg, snap_h, snap_neg, ap_h, ap_neg;
  logic [3:0]  cls, next_cls;
  logic [TW-1:0] trap_cnt;
  logic        trap_last;

  logic signed [12:0] dx, dy, adx, ady;
  logic        side_h, side_neg;

  logic signed [W-1:0] sx_w, sy_w, ax, ay;
  logic [SPEED_W-1:0]  new_x, new_y;

  function automatic logic [SPEED_W-1:0] clamp(input logic signed [W-1:0] v);
    if (v > MAX_W)       clamp = MAX_W[SPEED_W-1:0];
    else if (v < NMAX_W) clamp = NMAX_W[SPEED_W-1:0];
    else                 clamp = v[SPEED_W-1:0];
  endfunction

  assign pulses = {collisionBallBottom, collisionBallTrap, collisionBallBumper, collisionBallSpring,
                   collisionBallObstacleBad, collisionBallObstacleGood, collisionBallFlipper,
                   collisionBallFrame};

  // Hit side from the pixel offset to the ball centre; ties go to the horizontal axis.
  assign dx       = $signed({2'b00, pixelX}) - $signed({2'b00, ballX}) - HALF;
  assign dy       = $signed({2'b00, pixelY}) - $signed({2'b00, ballY}) - HALF;
  assign adx      = dx[12] ? -dx : dx;
  assign ady      = dy[12] ? -dy : dy;
  assign side_h   = (adx >= ady);
  assign side_neg = side_h ? dx[12] : dy[12];

  // Sticky per-frame flags and first-hit side; a boundary moves them to the snapshot and restarts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live     <= '0;
      live_h   <= 1'b0;
      live_neg <= 1'b0;
      snap     <= '0;
      snap_h   <= 1'b0;
      snap_neg <= 1'b0;
    end else if (startOfFrame) begin
      snap     <= live;
      snap_h   <= live_h;
      snap_neg <= live_neg;
      live     <= pulses;
      if (|pulses) begin
        live_h   <= side_h;
        live_neg <= side_neg;
      end
    end else begin
      live <= live | pulses;
      if ((|pulses) && (live == '0)) begin
        live_h   <= side_h;
        live_neg <= side_neg;
      end
    end
  end

  // Priority encode of the snapshot; a held ball ignores every collision.
  always_comb begin
    next_cls = C_NONE;
    if (trapped)               next_cls = C_HOLD;
    else if (snap[F_TRAP])     next_cls = C_TRAP;
    else if (snap[F_BOTTOM])   next_cls = C_BOTTOM;
    else if (snap[F_SPRING])   next_cls = C_SPRING;
    else if (snap[F_FLIP])     next_cls = C_FLIPPER;
    else if (snap[F_BUMPER])   next_cls = C_BUMPER;
    else if (snap[F_GOOD])     next_cls = C_GOOD;
    else if (snap[F_BAD])      next_cls = C_BAD;
    else if (snap[F_FRAME])    next_cls = C_FRAME;
  end

  // Sequencer: COLLECT -> RESOLVE -> APPLY, re-entering RESOLVE if a boundary arrived meanwhile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_COLLECT;
      pending <= 1'b0;
      cls     <= C_NONE;
      ap_h    <= 1'b0;
      ap_neg  <= 1'b0;
    end else begin
      case (state)
        S_COLLECT: if (startOfFrame) state <= S_RESOLVE;
        S_RESOLVE: begin
          cls    <= next_cls;
          ap_h   <= snap_h;
          ap_neg <= snap_neg;
          state  <= S_APPLY;
          if (startOfFrame) pending <= 1'b1;
        end
        S_APPLY: begin
          if (startOfFrame || pending) begin
            state   <= S_RESOLVE;
            pending <= 1'b0;
          end else begin
            state <= S_COLLECT;
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

  assign sx_w      = $signed({speedX[SPEED_W-1], speedX});
  assign sy_w      = $signed({speedY[SPEED_W-1], speedY});
  assign ax        = sx_w[W-1] ? -sx_w : sx_w;
  assign ay        = sy_w[W-1] ? -sy_w : sy_w;
  assign trap_last = (trap_cnt <= T_ONE);

  // New speed for the resolved class; reflections force the sign away from the hit side.
  always_comb begin
    new_x = speedX;
    new_y = speedY;
    case (cls)
      C_TRAP, C_BOTTOM: begin
        new_x = '0;
        new_y = '0;
      end
      C_SPRING:  new_y = clamp(-SPR_W);
      C_FLIPPER: new_y = clamp(-(ay + FB_W));
      C_BUMPER: begin
        new_x = clamp(sx_w[W-1] ? (ax + BB_W) : -(ax + BB_W));
        new_y = clamp(sy_w[W-1] ? (ay + BB_W) : -(ay + BB_W));
      end
      C_GOOD, C_BAD, C_FRAME: begin
        if (ap_h) new_x = clamp(ap_neg ? ax : -ax);
        else      new_y = clamp(ap_neg ? ay : -ay);
      end
      C_HOLD: begin
        new_x = '0;
        new_y = trap_last ? clamp(-SPR_W) : '0;
      end
      default:   new_y = clamp(sy_w + GRAV_W);
    endcase
  end

  // Output registers and trap hold counter, written once per frame in APPLY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      speedX     <= '0;
      speedY     <= '0;
      speedValid <= 1'b0;
      scoreDelta <= '0;
      scoreValid <= 1'b0;
      lifeLost   <= 1'b0;
      trapped    <= 1'b0;
      trap_cnt   <= '0;
    end else begin
      speedValid <= 1'b0;
      scoreValid <= 1'b0;
      lifeLost   <= 1'b0;
      if (state == S_APPLY) begin
        speedX     <= new_x;
        speedY     <= new_y;
        speedValid <= 1'b1;
        case (cls)
          C_TRAP: begin
            trapped  <= 1'b1;
            trap_cnt <= TRAP_LOAD;
          end
          C_BOTTOM: lifeLost <= 1'b1;
          C_GOOD: begin
            scoreValid <= 1'b1;
            scoreDelta <= GOOD_D;
          end
          C_BAD: begin
            scoreValid <= 1'b1;
            scoreDelta <= BAD_D;
          end
          C_HOLD: begin
            if (trap_last) begin
              trapped  <= 1'b0;
              trap_cnt <= '0;
            end else begin
              trap_cnt <= trap_cnt - T_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ball_collision_responder.sv
// Scoreboard bench for ball_collision_responder: a small integer model predicts each frame's result,
// the expectation is queued when startOfFrame is driven and popped when speedValid appears.
// Covers reset, priority, reflection, saturation, trap hold, coincident/pending frame boundaries.
module tb_ball_collision_responder;

  localparam logic [7:0] M_FRAME  = 8'h01;
  localparam logic [7:0] M_FLIP   = 8'h02;
  localparam logic [7:0] M_GOOD   = 8'h04;
  localparam logic [7:0] M_BAD    = 8'h08;
  localparam logic [7:0] M_SPRING = 8'h10;
  localparam logic [7:0] M_BUMPER = 8'h20;
  localparam logic [7:0] M_TRAP   = 8'h40;
  localparam logic [7:0] M_BOTTOM = 8'h80;

  localparam int LEFT = 0, RIGHT = 1, TOP = 2, BOT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic startOfFrame = 1'b0;
  logic c_frame = 1'b0, c_flip = 1'b0, c_good = 1'b0, c_bad = 1'b0;
  logic c_spring = 1'b0, c_bumper = 1'b0, c_trap = 1'b0, c_bottom = 1'b0;
  logic [10:0] pixelX = 11'd0, pixelY = 11'd0;
  logic [10:0] ballX = 11'd100, ballY = 11'd100;
  logic signed [10:0] speedX, speedY;
  logic signed [7:0]  scoreDelta;
  logic speedValid, scoreValid, lifeLost, trapped;

  typedef struct {
    int sx; int sy; int sv; int sd; int ll; int tr; int lat; int sof_cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   mx = 0, my = 0, mtrap = 0, mtcnt = 0;

  ball_collision_responder dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .collisionBallFrame(c_frame), .collisionBallFlipper(c_flip),
    .collisionBallObstacleGood(c_good), .collisionBallObstacleBad(c_bad),
    .collisionBallSpring(c_spring), .collisionBallBumper(c_bumper),
    .collisionBallTrap(c_trap), .collisionBallBottom(c_bottom),
    .pixelX(pixelX), .pixelY(pixelY), .ballX(ballX), .ballY(ballY),
    .speedX(speedX), .speedY(speedY), .speedValid(speedValid),
    .scoreDelta(scoreDelta), .scoreValid(scoreValid), .lifeLost(lifeLost), .trapped(trapped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic int clampv(input int v);
    return (v > 240) ? 240 : ((v < -240) ? -240 : v);
  endfunction

  function automatic int absv(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference behaviour for one frame, given the frame's pulse set and first-hit side.
  task automatic model_frame(input logic [7:0] m, input int side, output exp_t e);
    e = '{default: 0};
    if (mtrap != 0) begin
      mtcnt--;
      mx = 0;
      if (mtcnt == 0) begin mtrap = 0; my = -200; end
      else my = 0;
    end else if ((m & M_TRAP) != 0) begin
      mx = 0; my = 0; mtrap = 1; mtcnt = 60;
    end else if ((m & M_BOTTOM) != 0) begin
      mx = 0; my = 0; e.ll = 1;
    end else if ((m & M_SPRING) != 0) begin
      my = -200;
    end else if ((m & M_FLIP) != 0) begin
      my = -clampv(absv(my) + 40);
    end else if ((m & M_BUMPER) != 0) begin
      mx = (mx < 0) ? clampv(absv(mx) + 24) : clampv(-(absv(mx) + 24));
      my = (my < 0) ? clampv(absv(my) + 24) : clampv(-(absv(my) + 24));
    end else if ((m & (M_GOOD | M_BAD | M_FRAME)) != 0) begin
      case (side)
        LEFT:    mx = absv(mx);
        RIGHT:   mx = -absv(mx);
        TOP:     my = absv(my);
        default: my = -absv(my);
      endcase
      if ((m & M_GOOD) != 0)     begin e.sv = 1; e.sd = 10; end
      else if ((m & M_BAD) != 0) begin e.sv = 1; e.sd = -5; end
    end else begin
      my = clampv(my + 8);
    end
    e.sx = mx; e.sy = my; e.tr = mtrap; e.lat = 2;
  endtask

  task automatic drive(input logic [7:0] m);
    c_frame  = m[0]; c_flip   = m[1]; c_good = m[2]; c_bad    = m[3];
    c_spring = m[4]; c_bumper = m[5]; c_trap = m[6]; c_bottom = m[7];
  endtask

  task automatic set_pix(input int side);
    case (side)
      LEFT:    begin pixelX = 11'd100; pixelY = 11'd108; end
      RIGHT:   begin pixelX = 11'd116; pixelY = 11'd108; end
      TOP:     begin pixelX = 11'd108; pixelY = 11'd100; end
      default: begin pixelX = 11'd108; pixelY = 11'd116; end
    endcase
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    check("drain", sbq.size(), 0);
    @(negedge clk);
  endtask

  // One frame: up to two pulse events (first one fixes the side), then the closing startOfFrame.
  task automatic run_frame(input logic [7:0] m1, input int s1, input logic [7:0] m2, input int s2);
    exp_t e;
    if (m1 != 0) begin
      @(negedge clk); set_pix(s1); drive(m1);
      @(negedge clk); drive(8'h00);
    end
    if (m2 != 0) begin
      @(negedge clk); set_pix(s2); drive(m2);
      @(negedge clk); drive(8'h00);
    end
    @(negedge clk);
    model_frame(m1 | m2, (m1 != 0) ? s1 : s2, e);
    e.sof_cyc = cyc + 1;
    sbq.push_back(e);
    startOfFrame = 1'b1;
    @(negedge clk); startOfFrame = 1'b0;
    wait_drain();
  endtask

  // Scoreboard consumer: every speedValid pops one expectation; stray pulses are errors.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && speedValid) begin
      if (sbq.size() == 0) begin
        check("unexpected_speedValid", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("speedX", speedX, e.sx);
        check("speedY", speedY, e.sy);
        check("scoreValid", scoreValid, e.sv);
        if (e.sv != 0) check("scoreDelta", scoreDelta, e.sd);
        check("lifeLost", lifeLost, e.ll);
        check("trapped", trapped, e.tr);
        check("latency", cyc - e.sof_cyc, e.lat);
      end
    end else if (!reset && (scoreValid || lifeLost)) begin
      check("stray_pulse", 1, 0);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_speedX"}, speedX, 0);
    check({tag, "_speedY"}, speedY, 0);
    check({tag, "_speedValid"}, speedValid, 0);
    check({tag, "_scoreDelta"}, scoreDelta, 0);
    check({tag, "_scoreValid"}, scoreValid, 0);
    check({tag, "_lifeLost"}, lifeLost, 0);
    check({tag, "_trapped"}, trapped, 0);
  endtask

  initial begin : stim
    exp_t e1, e2;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    run_frame(8'h00, 0, 8'h00, 0);                    // gravity (0,8)
    run_frame(M_FRAME | M_BUMPER, LEFT, 8'h00, 0);    // bumper beats frame (-24,-32)
    run_frame(M_BUMPER, LEFT, 8'h00, 0);              // (48,56)
    run_frame(M_FRAME | M_BUMPER, TOP, 8'h00, 0);     // (-72,-80)
    run_frame(M_GOOD, LEFT, 8'h00, 0);                // speedX -> +72, +10
    check("good_left_x", speedX, 72);
    run_frame(M_BAD, RIGHT, 8'h00, 0);                // speedX -> -72, -5
    run_frame(M_FRAME, TOP, 8'h00, 0);                // speedY -> +80
    run_frame(M_FRAME, TOP, 8'h00, 0);                // repeat hit keeps +80
    run_frame(M_FRAME, LEFT, M_BAD, RIGHT);           // side fixed by first pulse -> +72
    for (int i = 0; i < 5; i++) run_frame(M_FLIP, 0, 8'h00, 0);  // to -240, saturated
    check("flip_sat", speedY, -240);
    for (int i = 0; i < 42; i++) run_frame(8'h00, 0, 8'h00, 0);  // up to +96
    check("pre_flip", speedY, 96);
    run_frame(M_FLIP, 0, 8'h00, 0);
    check("flip_from_96", speedY, -136);
    for (int i = 0; i < 48; i++) run_frame(8'h00, 0, 8'h00, 0);  // 232, 240, 240
    check("gravity_sat", speedY, 240);

    // Flipper pulse coincident with startOfFrame belongs to the next frame.
    @(negedge clk);
    model_frame(8'h00, 0, e1);
    e1.sof_cyc = cyc + 1;
    sbq.push_back(e1);
    drive(M_FLIP); startOfFrame = 1'b1;
    @(negedge clk); drive(8'h00); startOfFrame = 1'b0;
    wait_drain();
    model_frame(M_FLIP, 0, e2);
    e2.sof_cyc = cyc + 2;
    @(negedge clk);
    sbq.push_back(e2);
    startOfFrame = 1'b1;
    @(negedge clk); startOfFrame = 1'b0;
    wait_drain();
    check("coincident_flip", speedY, -240);

    run_frame(M_SPRING, 0, 8'h00, 0);                 // (72,-200)

    // Back-to-back frame boundaries: the second one is held pending, not dropped.
    @(negedge clk); set_pix(LEFT); drive(M_BUMPER);
    @(negedge clk); drive(8'h00);
    model_frame(M_BUMPER, LEFT, e1);
    model_frame(8'h00, 0, e2);
    e1.sof_cyc = cyc + 1;
    e2.sof_cyc = cyc + 2;
    e2.lat = 3;
    sbq.push_back(e1);
    sbq.push_back(e2);
    startOfFrame = 1'b1;
    @(negedge clk);
    @(negedge clk); startOfFrame = 1'b0;
    wait_drain();
    check("pending_y", speedY, 232);

    run_frame(M_BOTTOM, 0, 8'h00, 0);                 // life lost, speed 0
    run_frame(M_TRAP, 0, 8'h00, 0);                   // trapped
    for (int i = 0; i < 60; i++) begin
      case (i % 3)
        0:       run_frame(M_BOTTOM, 0, 8'h00, 0);
        1:       run_frame(M_SPRING | M_GOOD, LEFT, 8'h00, 0);
        default: run_frame(8'h00, 0, 8'h00, 0);
      endcase
    end
    check("trap_release_trapped", trapped, 0);
    check("trap_release_y", speedY, -200);
    run_frame(M_BUMPER, 0, 8'h00, 0);                 // (-24,224)

    // Reset while in APPLY: outputs return to reset values at once.
    @(negedge clk); startOfFrame = 1'b1;
    @(negedge clk); startOfFrame = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check_reset_outputs("reset_apply");
    mx = 0; my = 0; mtrap = 0; mtcnt = 0;
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_valid", speedValid, 0);
    run_frame(8'h00, 0, 8'h00, 0);                    // (0,8) with normal latency
    check("post_reset_y", speedY, 8);

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    check("queue_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
